// File: rtl/stereo_sample_fifo.sv
// Per-frame stereo capture into a registered FWFT FIFO; 1-clock push-to-output latency (2 with STEREO_FIFO_DCBLOCK_EN).
// Backpressure: out_ready low holds the head; pushes into a full FIFO without a pop are dropped and counted in ovf_cnt.
module stereo_sample_fifo #(
   parameter int VOICES       = 8,
   parameter int V_ENVS       = 8,
   parameter int V_WIDTH      = 3,
   parameter int E_WIDTH      = 3,
`ifdef _24BitAudio
   parameter int AUDIO_W      = 24,
`else
   parameter int AUDIO_W      = 16,
`endif
   parameter int DEPTH_LOG2   = 2,
`ifdef STEREO_FIFO_DCBLOCK_EN
   parameter int DC_SHIFT     = 8,
`endif
   parameter int CAPTURE_SLOT = (VOICES-1)*V_ENVS+2
) (
   input  logic                        sCLK_XVXENVS,
   input  logic                        reset_reg_N,
   input  logic [V_WIDTH+E_WIDTH-1:0]  xxxx,
   input  logic signed [AUDIO_W-1:0]   lsound_in,
   input  logic signed [AUDIO_W-1:0]   rsound_in,
   input  logic                        out_ready,
   output logic                        out_valid,
   output logic signed [AUDIO_W-1:0]   l_out,
   output logic signed [AUDIO_W-1:0]   r_out,
   output logic [DEPTH_LOG2:0]         fifo_level,
   output logic [7:0]                  ovf_cnt,
   output logic                        underrun,
   input  logic                        clr_flags
);

   localparam int XW    = V_WIDTH + E_WIDTH;
   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef logic [DEPTH_LOG2:0] ptr_t;
   typedef struct packed {
      logic signed [AUDIO_W-1:0] l;
      logic signed [AUDIO_W-1:0] r;
   } sample_t;

   sample_t          mem [DEPTH];
   ptr_t             wr_ptr, rd_ptr, wr_nxt, rd_nxt;
   logic [XW-1:0]    prev_xxxx;
   logic             cap, push_req, push_ok, pop, full, empty;
   logic             ovf_evt, urun_evt;
   sample_t          push_dat, head_dat;

   // Edge-detect on the slot so a stalled scan counter yields one capture per frame.
   assign cap = (xxxx == XW'(CAPTURE_SLOT)) && (prev_xxxx != XW'(CAPTURE_SLOT));

`ifdef STEREO_FIFO_DCBLOCK_EN
   localparam int IW = AUDIO_W + DC_SHIFT + 2;
   localparam logic signed [IW-1:0] SMAX = IW'((1 << (AUDIO_W-1)) - 1);
   localparam logic signed [IW-1:0] SMIN = -SMAX - IW'(1);

   logic signed [IW-1:0] xl_prev, xr_prev, yl, yr;
   logic                 cap_d;

   function automatic logic signed [IW-1:0] dc_step(input logic signed [AUDIO_W-1:0] x,
                                                    input logic signed [IW-1:0] xp,
                                                    input logic signed [IW-1:0] y);
      return IW'(x) - xp + y - (y >>> DC_SHIFT);
   endfunction

   function automatic logic signed [AUDIO_W-1:0] sat(input logic signed [IW-1:0] y);
      if (y > SMAX)      return SMAX[AUDIO_W-1:0];
      else if (y < SMIN) return SMIN[AUDIO_W-1:0];
      else               return y[AUDIO_W-1:0];
   endfunction

   always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
      if (!reset_reg_N) begin
         xl_prev <= '0;
         xr_prev <= '0;
         yl      <= '0;
         yr      <= '0;
         cap_d   <= 1'b0;
      end else begin
         cap_d <= cap;
         if (cap) begin
            xl_prev <= IW'(lsound_in);
            xr_prev <= IW'(rsound_in);
            yl      <= dc_step(lsound_in, xl_prev, yl);
            yr      <= dc_step(rsound_in, xr_prev, yr);
         end
      end
   end

   assign push_req = cap_d;
   assign push_dat = '{l: sat(yl), r: sat(yr)};
`else
   assign push_req = cap;
   assign push_dat = '{l: lsound_in, r: rsound_in};
`endif

   always_comb begin
      empty    = (wr_ptr == rd_ptr);
      full     = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
      pop      = out_valid && out_ready;
      push_ok  = push_req && (!full || pop);
      ovf_evt  = push_req && full && !pop;
      urun_evt = out_ready && empty && !out_valid;
      wr_nxt   = wr_ptr + ptr_t'(push_ok);
      rd_nxt   = rd_ptr + ptr_t'(pop);
      // Entry written this edge becomes the head only when it is the sole entry.
      if (push_ok && (wr_ptr == rd_nxt))
         head_dat = push_dat;
      else
         head_dat = mem[rd_nxt[DEPTH_LOG2-1:0]];
   end

   always_ff @(posedge sCLK_XVXENVS) begin
      if (push_ok)
         mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_dat;
   end

   always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
      if (!reset_reg_N) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         prev_xxxx <= '0;
         out_valid <= 1'b0;
         l_out     <= '0;
         r_out     <= '0;
         ovf_cnt   <= '0;
         underrun  <= 1'b0;
      end else begin
         prev_xxxx <= xxxx;
         wr_ptr    <= wr_nxt;
         rd_ptr    <= rd_nxt;
         out_valid <= (wr_nxt != rd_nxt);
         if (wr_nxt != rd_nxt) begin
            l_out <= head_dat.l;
            r_out <= head_dat.r;
         end
         if (clr_flags)
            ovf_cnt <= '0;
         else if (ovf_evt && (ovf_cnt != 8'hFF))
            ovf_cnt <= ovf_cnt + 8'd1;
         if (clr_flags)
            underrun <= 1'b0;
         else if (urun_evt)
            underrun <= 1'b1;
      end
   end

   assign fifo_level = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_stereo_sample_fifo.sv
// Directed bench for stereo_sample_fifo: frame capture, hold-at-slot, overflow, full push+pop, underrun, async reset.
module tb_stereo_sample_fifo;

   localparam int AW = 16;

   logic          sCLK_XVXENVS = 1'b0;
   logic          reset_reg_N;
   logic [5:0]    xxxx;
   logic [AW-1:0] lsound_in, rsound_in;
   logic          out_ready, clr_flags;
   logic          out_valid;
   logic [AW-1:0] l_out, r_out;
   logic [2:0]    fifo_level;
   logic [7:0]    ovf_cnt;
   logic          underrun;

   int total = 0;
   int bad   = 0;
   int vcnt;

   always #5 sCLK_XVXENVS = ~sCLK_XVXENVS;

   stereo_sample_fifo dut (
      .sCLK_XVXENVS (sCLK_XVXENVS),
      .reset_reg_N  (reset_reg_N),
      .xxxx         (xxxx),
      .lsound_in    (lsound_in),
      .rsound_in    (rsound_in),
      .out_ready    (out_ready),
      .out_valid    (out_valid),
      .l_out        (l_out),
      .r_out        (r_out),
      .fifo_level   (fifo_level),
      .ovf_cnt      (ovf_cnt),
      .underrun     (underrun),
      .clr_flags    (clr_flags)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Apply inputs for one cycle, then observe just after the rising edge.
   task automatic step(input logic [5:0] x, input logic rdy);
      xxxx      = x;
      out_ready = rdy;
      @(posedge sCLK_XVXENVS);
      #1;
   endtask

   task automatic push_one(input logic [AW-1:0] l, input logic [AW-1:0] r, input logic rdy);
      step(6'd57, 1'b0);
      lsound_in = l;
      rsound_in = r;
      step(6'd58, rdy);
   endtask

   initial begin
      reset_reg_N = 1'b0;
      xxxx        = '0;
      lsound_in   = 16'h1234;
      rsound_in   = 16'hEDCC;
      out_ready   = 1'b0;
      clr_flags   = 1'b0;
      repeat (3) @(posedge sCLK_XVXENVS);
      #1;
      check_val("rst_valid", 32'(out_valid), 32'd0);
      check_val("rst_l", 32'(l_out), 32'd0);
      check_val("rst_r", 32'(r_out), 32'd0);
      check_val("rst_level", 32'(fifo_level), 32'd0);
      check_val("rst_ovf", 32'(ovf_cnt), 32'd0);
      check_val("rst_urun", 32'(underrun), 32'd0);
      reset_reg_N = 1'b1;

      // Full scan sweeps with the consumer always ready.
      for (int f = 0; f < 2; f++) begin
         vcnt = 0;
         for (int x = 0; x < 64; x++) begin
            step(6'(x), 1'b1);
            if (out_valid) vcnt++;
            if (x == 58) begin
               check_val("sweep_valid_after_cap", 32'(out_valid), 32'd1);
               check_val("sweep_l", 32'(l_out), 32'h1234);
               check_val("sweep_r", 32'(r_out), 32'hEDCC);
            end
            if (x == 59)
               check_val("sweep_valid_one_clk", 32'(out_valid), 32'd0);
         end
         check_val("sweep_one_per_frame", 32'(vcnt), 32'd1);
      end
      check_val("sweep_ovf", 32'(ovf_cnt), 32'd0);

      // Underrun is sticky until cleared.
      check_val("urun_set", 32'(underrun), 32'd1);
      step(6'd0, 1'b0);
      check_val("urun_sticky", 32'(underrun), 32'd1);
      clr_flags = 1'b1;
      step(6'd0, 1'b1);
      clr_flags = 1'b0;
      check_val("urun_clr_wins", 32'(underrun), 32'd0);
      step(6'd0, 1'b0);
      check_val("urun_stays_clr", 32'(underrun), 32'd0);

      // Slot value held for 5 clocks gives a single push.
      lsound_in = 16'h0ABC;
      rsound_in = 16'h0DEF;
      step(6'd57, 1'b0);
      repeat (5) step(6'd58, 1'b0);
      step(6'd59, 1'b0);
      check_val("hold_level", 32'(fifo_level), 32'd1);
      check_val("hold_l", 32'(l_out), 32'h0ABC);
      step(6'd0, 1'b1);
      check_val("hold_drained", 32'(fifo_level), 32'd0);
      out_ready = 1'b0;

      // Six frames with no consumer: four stored, two dropped.
      for (int k = 1; k <= 6; k++)
         push_one(16'h1000 + 16'(k), 16'h2000 + 16'(k), 1'b0);
      check_val("ovf_level", 32'(fifo_level), 32'd4);
      check_val("ovf_cnt", 32'(ovf_cnt), 32'd2);
      for (int k = 1; k <= 4; k++) begin
         check_val("ovf_drain_valid", 32'(out_valid), 32'd1);
         check_val("ovf_drain_l", 32'(l_out), 32'h1000 + 32'(k));
         check_val("ovf_drain_r", 32'(r_out), 32'h2000 + 32'(k));
         step(6'd0, 1'b1);
      end
      out_ready = 1'b0;
      check_val("ovf_empty_valid", 32'(out_valid), 32'd0);
      check_val("ovf_empty_level", 32'(fifo_level), 32'd0);
      check_val("empty_hold_l", 32'(l_out), 32'h1004);

      // Full FIFO, capture coincides with a pop.
      for (int k = 1; k <= 4; k++)
         push_one(16'h3000 + 16'(k), 16'h4000 + 16'(k), 1'b0);
      check_val("full_level", 32'(fifo_level), 32'd4);
      push_one(16'h3005, 16'h4005, 1'b1);
      check_val("full_pp_level", 32'(fifo_level), 32'd4);
      check_val("full_pp_ovf", 32'(ovf_cnt), 32'd2);
      for (int k = 2; k <= 5; k++) begin
         check_val("full_pp_l", 32'(l_out), 32'h3000 + 32'(k));
         check_val("full_pp_r", 32'(r_out), 32'h4000 + 32'(k));
         step(6'd0, 1'b1);
      end
      out_ready = 1'b0;
      check_val("full_pp_empty", 32'(fifo_level), 32'd0);
      clr_flags = 1'b1;
      step(6'd0, 1'b0);
      clr_flags = 1'b0;
      check_val("ovf_clr", 32'(ovf_cnt), 32'd0);

      // Asynchronous reset with three entries stored.
      for (int k = 1; k <= 3; k++)
         push_one(16'h5000 + 16'(k), 16'h6000 + 16'(k), 1'b0);
      check_val("pre_rst_level", 32'(fifo_level), 32'd3);
      #2;
      reset_reg_N = 1'b0;
      #1;
      check_val("arst_valid", 32'(out_valid), 32'd0);
      check_val("arst_level", 32'(fifo_level), 32'd0);
      @(posedge sCLK_XVXENVS);
      #1;
      reset_reg_N = 1'b1;
      step(6'd0, 1'b0);
      check_val("post_rst_level", 32'(fifo_level), 32'd0);
      lsound_in = 16'h7777;
      rsound_in = 16'h8888;
      step(6'd58, 1'b0);
      check_val("post_rst_cap_level", 32'(fifo_level), 32'd1);
      check_val("post_rst_cap_l", 32'(l_out), 32'h7777);
      check_val("post_rst_cap_r", 32'(r_out), 32'h8888);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stereo_sample_fifo.md
Name: stereo_sample_fifo

Overview:
- Output stage directly downstream of the synth engine mixer.
- Captures the mixer's stereo sample once per voice/envelope frame, at a fixed slot of the xxxx scan counter.
- Buffers captured samples in a small synchronous FIFO and presents them to the codec/serializer stage over a valid/ready handshake.
- Tracks overflow and underrun so frame-rate vs. codec-rate mismatches are observable.

Parameters:
- VOICES, 8, voices per frame; must match the mixer.
- V_ENVS, 8, envelopes per voice; must match the mixer.
- V_WIDTH, 3, voice index width of xxxx.
- E_WIDTH, 3, envelope index width of xxxx.
- AUDIO_W, 16, sample width per channel (24 when `_24BitAudio is defined).
- DEPTH_LOG2, 2, FIFO depth = 2**DEPTH_LOG2 stereo entries.
- CAPTURE_SLOT, (VOICES-1)*V_ENVS+2, xxxx value at which the mixer output is stable and is sampled.
- DC_SHIFT, 8, DC-blocker pole shift (optional feature only).

Ports:
- sCLK_XVXENVS  in  1  clock, rising edge.
- reset_reg_N  in  1  reset, asynchronous, active-low.
- xxxx  in  V_WIDTH+E_WIDTH  voice/envelope scan index.
- lsound_in  in  AUDIO_W signed  mixer left sample.
- rsound_in  in  AUDIO_W signed  mixer right sample.
- out_ready  in  1  consumer accepts head entry.
- out_valid  out  1  head entry valid.
- l_out  out  AUDIO_W signed  head left sample.
- r_out  out  AUDIO_W signed  head right sample.
- fifo_level  out  DEPTH_LOG2+1  entries stored.
- ovf_cnt  out  8  dropped-sample count, saturating.
- underrun  out  1  sticky: consumer was ready while FIFO empty.
- clr_flags  in  1  synchronous clear of ovf_cnt and underrun.

Behaviour:
- Reset (async, active-low):
  - out_valid=0, l_out=r_out=0, fifo_level=0, ovf_cnt=0, underrun=0.
  - Read/write pointers = 0; prev_xxxx register = 0.
  - Reset asserted mid-frame discards all stored entries; the first capture after release is the next qualifying CAPTURE_SLOT edge.
- Capture strobe:
  - cap = (xxxx==CAPTURE_SLOT) && (prev_xxxx!=CAPTURE_SLOT); prev_xxxx is registered every cycle.
  - Exactly one strobe per frame, even if xxxx holds the slot value for several clocks.
- Push: on cap, {lsound_in,rsound_in} is written at wr_ptr.
  - Push is accepted if level < DEPTH, or if a pop occurs in the same cycle.
- Pop: on out_valid && out_ready at a rising edge, rd_ptr advances.
- Pointers are DEPTH_LOG2+1 bits with natural wrap; full/empty are decided by the MSB comparison.
- Output timing (first-word-fall-through, registered):
  - l_out, r_out and out_valid update one clock after the pointer change.
  - Push into an empty FIFO gives out_valid=1 on the next clock.
  - Push-to-output latency is 1 clock.
  - When the FIFO is empty, l_out/r_out hold their last value and out_valid=0.
- Simultaneous push+pop:
  - Non-empty and not full: both are accepted and level is unchanged.
  - Full: both are accepted, the new entry is stored and no overflow is counted.
  - Empty: the pop is impossible because out_valid=0; the push alone is accepted.
- Overflow: push while full with no pop. The sample is dropped, ovf_cnt increments and saturates at 255, and FIFO contents are unchanged.
- Underrun: out_ready=1 while level==0 and out_valid==0 sets underrun, which stays set until clr_flags.
- clr_flags priority: if clr_flags and a new overflow/underrun event occur in the same cycle, clr_flags wins and the event is not recorded.
- Arithmetic: no scaling; samples are stored bit-exact. fifo_level = wr_ptr - rd_ptr, modulo 2**(DEPTH_LOG2+1).

Optional Feature:
- Macro STEREO_FIFO_DCBLOCK_EN.
- Defined: each channel passes through a DC blocker before the push.
  - y[n] = x[n] - x[n-1] + y[n-1] - (y[n-1] >>> DC_SHIFT).
  - Internal width AUDIO_W+DC_SHIFT+2; the result saturates to AUDIO_W signed.
  - State updates only on cap and is cleared by reset.
  - Adds 1 clock: the push occurs the cycle after cap.
- Undefined: samples pass unmodified, the push occurs on the cap cycle, and the DC-blocker state registers do not exist.

Test Plan:
- Reset release, xxxx sweeps 0..63 repeatedly with lsound_in=0x1234, rsound_in=0xEDCC, out_ready=1 → exactly one entry per frame; out_valid pulses 1 clock after cap; l_out=0x1234, r_out=0xEDCC; ovf_cnt=0.
- xxxx held at CAPTURE_SLOT=58 for 5 clocks → single push, fifo_level=1.
- out_ready=0 for 6 frames (DEPTH=4) → fifo_level=4, ovf_cnt=2; samples 1-4 drained in order, samples 5-6 absent.
- FIFO full, cap coincides with out_ready=1 pop → level stays 4, ovf_cnt unchanged, new sample at tail.
- FIFO empty, out_ready=1 → underrun=1; remains set until clr_flags=1, then 0 on the next clock.
- reset_reg_N pulsed low with 3 entries stored → out_valid=0, fifo_level=0 immediately (asynchronously); with STEREO_FIFO_DCBLOCK_EN, constant input 0x1000 decays toward 0 across frames.
